// File: rtl/player_action_ctrl.sv
`default_nettype none
// player_action_ctrl: two-player box movement, facing and attack/hit logic,
// advanced once per game tick derived from clk by CLK_DIV.
module player_action_ctrl #(
    parameter int CLK_DIV      = 1000000,
    parameter int SCREEN_W     = 96,
    parameter int SCREEN_H     = 64,
    parameter int SPRITE       = 8,
    parameter int REACH        = 6,
    parameter int ACTIVE_TICKS = 10,
    parameter int COOL_TICKS   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] game_controls,
    output logic [6:0] p1_x,
    output logic [5:0] p1_y,
    output logic [6:0] p2_x,
    output logic [5:0] p2_y,
    output logic       p1_face,
    output logic       p2_face,
    output logic [1:0] p1_atk_st,
    output logic [1:0] p2_atk_st,
    output logic       p1_hit,
    output logic       p2_hit,
    output logic [1:0] p1_dmg,
    output logic [1:0] p2_dmg
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMAX = (ACTIVE_TICKS > COOL_TICKS) ? ACTIVE_TICKS : COOL_TICKS;
    localparam int SW = $clog2(TMAX + 1);

    localparam logic [CW-1:0] C_TICK_LAST   = CW'(CLK_DIV - 1);
    localparam logic [SW-1:0] C_ACT_LAST    = SW'(ACTIVE_TICKS - 1);
    localparam logic [SW-1:0] C_COOL_LAST   = SW'(COOL_TICKS - 1);
    localparam logic [7:0]    C_X_MAX       = 8'(SCREEN_W - SPRITE);
    localparam logic [6:0]    C_Y_MAX       = 7'(SCREEN_H - SPRITE);
    localparam logic [6:0]    C_SPR7        = 7'(SPRITE);
    localparam logic [7:0]    C_SPR_REACH   = 8'(SPRITE + REACH);
    localparam logic [6:0]    C_P2_X_RESET  = 7'(SCREEN_W - 16);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_COOL   = 2'b10
    } atk_st_t;

    logic [CW-1:0] cnt_q;
    logic          tick;

    logic [6:0]    x_q   [2];
    logic [5:0]    y_q   [2];
    logic          face_q[2];
    atk_st_t       st_q  [2];
    logic [SW-1:0] sub_q [2];
    logic [1:0]    typ_q [2];
    logic          done_q[2];
    logic          hit_q [2];
    logic [1:0]    dmg_q [2];

    logic [7:0]    x_dec [2];
    logic [7:0]    x_inc [2];
    logic [6:0]    y_dec [2];
    logic [6:0]    y_inc [2];
    logic [6:0]    x_d   [2];
    logic [5:0]    y_d   [2];
    logic          face_d[2];
    logic          in_zone[2];
    logic          blocked;

    function automatic logic [6:0] f_adiff(input logic [6:0] a, input logic [6:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    assign tick = (cnt_q == C_TICK_LAST);

    always_comb begin
        blocked = 1'b0;
        for (int p = 0; p < 2; p++) begin
            // One extra bit: the top bit flags an underflow or a step past the bound.
            x_dec[p]  = {1'b0, x_q[p]} - 8'd1;
            x_inc[p]  = {1'b0, x_q[p]} + 8'd1;
            y_dec[p]  = {1'b0, y_q[p]} - 7'd1;
            y_inc[p]  = {1'b0, y_q[p]} + 7'd1;
            x_d[p]    = x_q[p];
            y_d[p]    = y_q[p];
            face_d[p] = face_q[p];
            in_zone[p] = 1'b0;
            if (st_q[p] != ST_ACTIVE) begin
                case (game_controls[5*p +: 3])
                    3'b001: if (!y_dec[p][6]) y_d[p] = y_dec[p][5:0];
                    3'b010: begin
                        face_d[p] = 1'b0;
                        if (!x_dec[p][7]) x_d[p] = x_dec[p][6:0];
                    end
                    3'b011: if (y_inc[p] <= C_Y_MAX) y_d[p] = y_inc[p][5:0];
                    3'b100: begin
                        face_d[p] = 1'b1;
                        if (x_inc[p] <= C_X_MAX) x_d[p] = x_inc[p][6:0];
                    end
                    default: ;
                endcase
            end
        end
        blocked = (f_adiff(x_d[0], x_d[1]) < C_SPR7) &&
                  (f_adiff({1'b0, y_d[0]}, {1'b0, y_d[1]}) < C_SPR7);
        for (int p = 0; p < 2; p++) begin
            // Left zone start x-REACH is compared as opp+SPRITE+REACH > x to stay unsigned.
            if (f_adiff({1'b0, y_q[p]}, {1'b0, y_q[1-p]}) < C_SPR7) begin
                if (face_q[p])
                    in_zone[p] = ({1'b0, x_q[1-p]} < ({1'b0, x_q[p]} + C_SPR_REACH)) &&
                                 (x_q[1-p] > x_q[p]);
                else
                    in_zone[p] = (x_q[1-p] < x_q[p]) &&
                                 (({1'b0, x_q[1-p]} + C_SPR_REACH) > {1'b0, x_q[p]});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            x_q[0]    <= 7'd8;
            x_q[1]    <= C_P2_X_RESET;
            y_q[0]    <= 6'd28;
            y_q[1]    <= 6'd28;
            face_q[0] <= 1'b1;
            face_q[1] <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                st_q[p]   <= ST_IDLE;
                sub_q[p]  <= '0;
                typ_q[p]  <= 2'b00;
                done_q[p] <= 1'b0;
                hit_q[p]  <= 1'b0;
                dmg_q[p]  <= 2'b00;
            end
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            for (int p = 0; p < 2; p++) begin
                hit_q[p] <= 1'b0;
                dmg_q[p] <= 2'b00;
                if (tick) begin
                    face_q[p] <= face_d[p];
                    if (!blocked) begin
                        x_q[p] <= x_d[p];
                        y_q[p] <= y_d[p];
                    end
                    case (st_q[p])
                        ST_IDLE: begin
                            if (game_controls[5*p+3 +: 2] == 2'b01 ||
                                game_controls[5*p+3 +: 2] == 2'b10) begin
                                st_q[p]   <= ST_ACTIVE;
                                typ_q[p]  <= game_controls[5*p+3 +: 2];
                                sub_q[p]  <= '0;
                                done_q[p] <= 1'b0;
                            end
                        end
                        ST_ACTIVE: begin
                            if (!done_q[p] && in_zone[p]) begin
                                hit_q[p]  <= 1'b1;
                                dmg_q[p]  <= typ_q[p];
                                done_q[p] <= 1'b1;
                            end
                            if (sub_q[p] == C_ACT_LAST) begin
                                st_q[p]  <= ST_COOL;
                                sub_q[p] <= '0;
                            end else begin
                                sub_q[p] <= sub_q[p] + 1'b1;
                            end
                        end
                        ST_COOL: begin
                            if (sub_q[p] == C_COOL_LAST) begin
                                st_q[p]  <= ST_IDLE;
                                sub_q[p] <= '0;
                            end else begin
                                sub_q[p] <= sub_q[p] + 1'b1;
                            end
                        end
                        default: st_q[p] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign p1_x      = x_q[0];
    assign p1_y      = y_q[0];
    assign p2_x      = x_q[1];
    assign p2_y      = y_q[1];
    assign p1_face   = face_q[0];
    assign p2_face   = face_q[1];
    assign p1_atk_st = st_q[0];
    assign p2_atk_st = st_q[1];
    assign p1_hit    = hit_q[0];
    assign p2_hit    = hit_q[1];
    assign p1_dmg    = dmg_q[0];
    assign p2_dmg    = dmg_q[1];

endmodule
`default_nettype wire

// File: doc/player_action_ctrl.md
PLAYER_ACTION_CTRL -- requirements
Module: player_action_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 1000000, meaning clk cycles per game tick (100 Hz at 100 MHz).
REQ-002 Parameter SCREEN_W, default 96, meaning playfield width in pixels.
REQ-003 Parameter SCREEN_H, default 64, meaning playfield height in pixels.
REQ-004 Parameter SPRITE, default 8, meaning square player box size in pixels.
REQ-005 Parameter REACH, default 6, meaning attack reach in pixels beyond the box edge.
REQ-006 Parameter ACTIVE_TICKS, default 10, meaning ticks an attack stays active.
REQ-007 Parameter COOL_TICKS, default 20, meaning cooldown ticks after an attack.
REQ-008 clk  input  1  system clock; the single clock, all logic on its rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 game_controls  input  10  {p2_atk[1:0], p2_move[2:0], p1_atk[1:0], p1_move[2:0]}; move 001 up, 010 left, 011 down, 100 right, others none; atk 01 light, 10 heavy, 00/11 none.
REQ-011 p1_x, p2_x  output  7 each  box left x; p1_y, p2_y  output  6 each  box top y.
REQ-012 p1_face, p2_face  output  1 each  1 = facing right, 0 = facing left.
REQ-013 p1_atk_st, p2_atk_st  output  2 each  00 IDLE, 01 ACTIVE, 10 COOL.
REQ-014 p1_hit, p2_hit  output  1 each  one-cycle pulse: this player's attack connected.
REQ-015 p1_dmg, p2_dmg  output  2 each  damage of the connecting attack, valid with the hit pulse (light 1, heavy 2).

Function
REQ-016 Tick counter SHALL count 0..CLK_DIV-1 and wrap; tick is asserted in the cycle the count equals CLK_DIV-1.
REQ-017 game_controls SHALL be sampled only in tick cycles; all state updates occur on that edge and are visible on outputs one cycle after the tick.
REQ-018 Per player, movement SHALL be one pixel per tick in the coded direction, suppressed while that player is ACTIVE.
REQ-019 Movement SHALL saturate: x in [0, SCREEN_W-SPRITE], y in [0, SCREEN_H-SPRITE]; a move past a bound holds the coordinate (no wrap).
REQ-020 Both candidate positions SHALL be computed in the same tick; if the candidate boxes overlap, neither player moves that tick; otherwise both apply.
REQ-021 Left move SHALL set face=0, right move face=1, even when movement is blocked by a bound or overlap; up/down leave face unchanged.
REQ-022 Attack FSM per player: IDLE -> ACTIVE on a tick with atk 01/10 (type latched); ACTIVE -> COOL after ACTIVE_TICKS ticks; COOL -> IDLE after COOL_TICKS ticks; atk inputs ignored outside IDLE.
REQ-023 Hit zone: |y_self - y_opp| < SPRITE and opponent box horizontally intersecting [x+SPRITE, x+SPRITE+REACH) when facing right, or [x-REACH, x) when facing left.
REQ-024 While ACTIVE, on each tick the hit zone SHALL be tested; first positive test raises pN_hit for exactly one cycle with pN_dmg from the latched type; at most one hit per attack.
REQ-025 Both players may hit in the same tick; both pulses assert in the same cycle.
REQ-026 pN_dmg SHALL read 0 whenever pN_hit is low.
REQ-027 Coordinate arithmetic SHALL use one extra bit internally so left/up moves from 0 and reach calculations never underflow.

Reset
REQ-028 While rst is high at a clk edge: tick counter 0; p1 at (8,28) face 1; p2 at (SCREEN_W-16,28) face 0; both FSMs IDLE; hit/dmg 0; per-attack hit flags and tick sub-counters 0.
REQ-029 rst asserted mid-attack or mid-count SHALL abandon that operation; the first tick after release occurs CLK_DIV cycles after the release edge.

Verification (CLK_DIV=4, defaults otherwise)
REQ-030 p1_move=010 held from reset for 10 ticks -> p1_x 8,7,...,0 then holds 0; p1_face=0 throughout.
REQ-031 p1 at (40,28) face 1, p2 at (49,28); p1 right, p2 left same tick -> candidates 41/48 overlap, both x unchanged, faces updated to 1/0.
REQ-032 p1 at (40,28) face 1, p2 at (52,28); p1_atk=10 one tick -> p1_atk_st 01 for 10 ticks, single p1_hit pulse with p1_dmg=2 one cycle after first active tick, then 10 for 20 ticks, then 00.
REQ-033 atk=01 pressed during ACTIVE and COOL -> no restart; atk held continuously -> new attack starts on first tick after returning to IDLE.
REQ-034 p2 moved out of hit zone before p1 attacks, then moved in during ACTIVE -> hit pulses on the first tick in zone; no pulse during COOL.
REQ-035 rst pulsed for one cycle during ACTIVE with p1 at (30,10) -> next cycle all outputs at reset values; first tick 4 cycles after release.
